// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The entry record pairs each instruction with the PC it was fetched from.
package fetch_pkg;

    localparam int FETCH_W = 4;
    localparam int INST_W  = 32;
    localparam int PC_W    = 32;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Ceiling log2, usable in constant expressions for index widths.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the instruction memory, redirect and decode-side signals of the fetch queue.
// master is the queue side, slave is the surrounding pipeline/memory side.
interface fetch_queue_if;
    import fetch_pkg::*;

    logic [PC_W-1:0]   imem_addr;
    logic [PC_W-1:0]   imem_jump_addr;
    logic [INST_W-1:0] imem_rd0;
    logic [INST_W-1:0] imem_rd1;
    logic [INST_W-1:0] imem_rd2;
    logic [INST_W-1:0] imem_rd3;
    logic [INST_W-1:0] imem_jump_rd0;
    logic [INST_W-1:0] imem_jump_rd1;
    logic [INST_W-1:0] imem_jump_rd2;
    logic [INST_W-1:0] imem_jump_rd3;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic [3:0]        out_valid;
    logic [INST_W-1:0] out_inst0;
    logic [INST_W-1:0] out_inst1;
    logic [INST_W-1:0] out_inst2;
    logic [INST_W-1:0] out_inst3;
    logic [PC_W-1:0]   out_pc0;
    logic [PC_W-1:0]   out_pc1;
    logic [PC_W-1:0]   out_pc2;
    logic [PC_W-1:0]   out_pc3;
    logic [2:0]        deq_count;

    modport master (
        output imem_addr, imem_jump_addr,
        input  imem_rd0, imem_rd1, imem_rd2, imem_rd3,
        input  imem_jump_rd0, imem_jump_rd1, imem_jump_rd2, imem_jump_rd3,
        input  redirect_valid, redirect_pc, deq_count,
        output out_valid,
        output out_inst0, out_inst1, out_inst2, out_inst3,
        output out_pc0, out_pc1, out_pc2, out_pc3
    );

    modport slave (
        input  imem_addr, imem_jump_addr,
        output imem_rd0, imem_rd1, imem_rd2, imem_rd3,
        output imem_jump_rd0, imem_jump_rd1, imem_jump_rd2, imem_jump_rd3,
        output redirect_valid, redirect_pc, deq_count,
        input  out_valid,
        input  out_inst0, out_inst1, out_inst2, out_inst3,
        input  out_pc0, out_pc1, out_pc2, out_pc3
    );

endinterface

// File: rtl/fetch_queue_storage.sv
// Circular entry array: four writes at consecutive wrapped indices, four reads from head.
// Contents are deliberately not reset; occupancy tracking lives in the parent.
module fetch_queue_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int IDX_W = clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_base,
    input  fetch_entry_t [FETCH_W-1:0]  wr_data,
    input  logic [IDX_W-1:0]            rd_base,
    output fetch_entry_t [FETCH_W-1:0]  rd_data
);

    fetch_entry_t mem_q [DEPTH];

    // DEPTH is a power of two, so index overflow wraps naturally.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < FETCH_W; i++) begin
                mem_q[wr_base + IDX_W'(i)] <= wr_data[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            rd_data[i] = mem_q[rd_base + IDX_W'(i)];
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential 4-wide fetch into a circular buffer, up to 4
// oldest entries presented to decode, and same-cycle refill from the jump port on redirect.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 8,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);

    localparam int IDX_W = clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FETCH_C = CNT_W'(FETCH_W);

    logic [PC_W-1:0]  pc_q,    pc_d;
    logic [IDX_W-1:0] head_q,  head_d;
    logic [IDX_W-1:0] tail_q,  tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [INST_W-1:0] seq_rd    [FETCH_W];
    logic [INST_W-1:0] jump_rd   [FETCH_W];
    fetch_entry_t      seq_entry [FETCH_W];
    fetch_entry_t      jump_entry[FETCH_W];

    logic [PC_W-1:0]           jump_base;
    logic [2:0]                deq_sat;
    logic [CNT_W-1:0]          eff_deq;
    logic                      fetch_en;
    logic                      wr_en;
    logic [IDX_W-1:0]          wr_base;
    fetch_entry_t [FETCH_W-1:0] wr_data;
    fetch_entry_t [FETCH_W-1:0] rd_data;
    logic [FETCH_W-1:0]        out_valid_w;

    assign seq_rd[0]  = bus.imem_rd0;
    assign seq_rd[1]  = bus.imem_rd1;
    assign seq_rd[2]  = bus.imem_rd2;
    assign seq_rd[3]  = bus.imem_rd3;
    assign jump_rd[0] = bus.imem_jump_rd0;
    assign jump_rd[1] = bus.imem_jump_rd1;
    assign jump_rd[2] = bus.imem_jump_rd2;
    assign jump_rd[3] = bus.imem_jump_rd3;

    assign jump_base          = {bus.redirect_pc[PC_W-1:2], 2'b00};
    assign bus.imem_addr      = pc_q;
    assign bus.imem_jump_addr = jump_base;

    generate
        for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_entry
            assign seq_entry[gi]  = '{pc: pc_q + PC_W'(4 * gi),      inst: seq_rd[gi]};
            assign jump_entry[gi] = '{pc: jump_base + PC_W'(4 * gi), inst: jump_rd[gi]};
            assign out_valid_w[gi] = (count_q > CNT_W'(gi));
        end
    endgenerate

    // Fetch decision uses only registered occupancy: no path from deq_count to imem_addr.
    assign deq_sat  = (bus.deq_count > 3'd4) ? 3'd4 : bus.deq_count;
    assign eff_deq  = (CNT_W'(deq_sat) < count_q) ? CNT_W'(deq_sat) : count_q;
    assign fetch_en = ((DEPTH_C - count_q) >= FETCH_C);

    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_base = tail_q;
        wr_data = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            wr_data[i] = seq_entry[i];
        end

        if (bus.redirect_valid) begin
            wr_en   = 1'b1;
            wr_base = '0;
            for (int i = 0; i < FETCH_W; i++) begin
                wr_data[i] = jump_entry[i];
            end
            head_d  = '0;
            tail_d  = IDX_W'(FETCH_W);
            count_d = FETCH_C;
            pc_d    = jump_base + PC_W'(4 * FETCH_W);
        end else begin
            head_d = head_q + eff_deq[IDX_W-1:0];
            if (fetch_en) begin
                wr_en   = 1'b1;
                tail_d  = tail_q + IDX_W'(FETCH_W);
                pc_d    = pc_q + PC_W'(4 * FETCH_W);
                count_d = count_q + FETCH_C - eff_deq;
            end else begin
                count_d = count_q - eff_deq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count_q <= DEPTH_C);
        end
    end

    fetch_queue_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_base (wr_base),
        .wr_data (wr_data),
        .rd_base (head_q),
        .rd_data (rd_data)
    );

    assign bus.out_valid = out_valid_w;
    assign bus.out_inst0 = rd_data[0].inst;
    assign bus.out_inst1 = rd_data[1].inst;
    assign bus.out_inst2 = rd_data[2].inst;
    assign bus.out_inst3 = rd_data[3].inst;
    assign bus.out_pc0   = rd_data[0].pc;
    assign bus.out_pc1   = rd_data[1].pc;
    assign bus.out_pc2   = rd_data[2].pc;
    assign bus.out_pc3   = rd_data[3].pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: the memory model returns address-tagged words
// (0xC... sequential port, 0xD... jump port) so every slot's inst can be tied to its PC.
module tb_fetch_queue;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    localparam logic [31:0] SEQ_TAG  = 32'hC000_0000;
    localparam logic [31:0] JUMP_TAG = 32'hD000_0000;

    fetch_queue_if bus();

    fetch_queue #(
        .DEPTH    (8),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.imem_rd0      = SEQ_TAG  | (bus.imem_addr);
    assign bus.imem_rd1      = SEQ_TAG  | (bus.imem_addr + 32'd4);
    assign bus.imem_rd2      = SEQ_TAG  | (bus.imem_addr + 32'd8);
    assign bus.imem_rd3      = SEQ_TAG  | (bus.imem_addr + 32'd12);
    assign bus.imem_jump_rd0 = JUMP_TAG | (bus.imem_jump_addr);
    assign bus.imem_jump_rd1 = JUMP_TAG | (bus.imem_jump_addr + 32'd4);
    assign bus.imem_jump_rd2 = JUMP_TAG | (bus.imem_jump_addr + 32'd8);
    assign bus.imem_jump_rd3 = JUMP_TAG | (bus.imem_jump_addr + 32'd12);

    logic [31:0] opc  [4];
    logic [31:0] oinst[4];
    assign opc[0]   = bus.out_pc0;
    assign opc[1]   = bus.out_pc1;
    assign opc[2]   = bus.out_pc2;
    assign opc[3]   = bus.out_pc3;
    assign oinst[0] = bus.out_inst0;
    assign oinst[1] = bus.out_inst1;
    assign oinst[2] = bus.out_inst2;
    assign oinst[3] = bus.out_inst3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks the valid mask, contiguous PCs from p0 in valid slots, their tagged insts, and imem_addr.
    task automatic chk_q(input string tag, input logic [3:0] v, input logic [31:0] p0,
                         input logic [31:0] tagbits, input logic [31:0] addr);
        logic [31:0] p;
        chk({tag, ".valid"}, {28'd0, bus.out_valid}, {28'd0, v});
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                p = p0 + 32'(4 * i);
                chk($sformatf("%s.pc%0d", tag, i), opc[i], p);
                chk($sformatf("%s.inst%0d", tag, i), oinst[i], tagbits | p);
            end
        end
        chk({tag, ".imem_addr"}, bus.imem_addr, addr);
        $display("[TB] %s: valid=%b pc0=%h imem_addr=%h", tag, bus.out_valid, opc[0], bus.imem_addr);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0000_0047;
        bus.deq_count      = 3'd0;
        tick();
        reset = 1'b0;
        chk_q("reset", 4'b0000, 32'h0, SEQ_TAG, 32'h0);
        chk("jump_addr_idle", bus.imem_jump_addr, 32'h0000_0044);

        tick();
        chk_q("fill1", 4'b1111, 32'h0, SEQ_TAG, 32'h10);
        tick();
        chk_q("fill2", 4'b1111, 32'h0, SEQ_TAG, 32'h20);
        tick();
        chk_q("full_hold", 4'b1111, 32'h0, SEQ_TAG, 32'h20);

        bus.deq_count = 3'd3;
        tick();
        chk_q("deq3_stall", 4'b1111, 32'hC, SEQ_TAG, 32'h20);
        bus.deq_count = 3'd1;
        tick();
        chk_q("deq1_stall", 4'b1111, 32'h10, SEQ_TAG, 32'h20);
        bus.deq_count = 3'd0;
        tick();
        chk_q("refetch", 4'b1111, 32'h10, SEQ_TAG, 32'h30);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        bus.deq_count      = 3'd4;
        #1;
        chk("jump_addr", bus.imem_jump_addr, 32'h0000_0100);
        tick();
        bus.redirect_valid = 1'b0;
        chk_q("redirect", 4'b1111, 32'h100, JUMP_TAG, 32'h110);

        for (int k = 1; k <= 10; k++) begin
            tick();
            chk_q($sformatf("steady%0d", k), 4'b1111, 32'h100 + 32'(16 * k), SEQ_TAG,
                  32'h110 + 32'(16 * k));
        end

        bus.deq_count = 3'd2;
        tick();
        chk_q("deq2_grow", 4'b1111, 32'h1A8, SEQ_TAG, 32'h1C0);
        bus.deq_count = 3'd4;
        tick();
        chk_q("count2", 4'b0011, 32'h1B8, SEQ_TAG, 32'h1C0);
        tick();
        chk_q("clamp", 4'b1111, 32'h1C0, SEQ_TAG, 32'h1D0);
        bus.deq_count = 3'd2;
        tick();
        chk_q("count6", 4'b1111, 32'h1C8, SEQ_TAG, 32'h1E0);

        reset              = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        bus.deq_count      = 3'd0;
        tick();
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        chk_q("reset_wins", 4'b0000, 32'h0, SEQ_TAG, 32'h0);

        bus.deq_count = 3'd4;
        tick();
        chk_q("empty_deq", 4'b1111, 32'h0, SEQ_TAG, 32'h10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Front-end requester for the 4-wide instruction memory.
- Drives the sequential fetch address and the jump-target fetch address.
- Captures each returned 4-instruction bundle, tagged with per-instruction PCs, into a circular queue.
- Presents up to 4 oldest instructions per cycle to decode.
- On redirect, flushes the queue and refills it from the jump read path in the same cycle, so a taken jump costs zero fetch bubbles.

Parameters:
- DEPTH, 8: queue entries; power of two, >= 8.
- RESET_PC, 32'h0000_0000: PC loaded on reset; word aligned.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- imem_addr  out  32  sequential fetch address (imem A).
- imem_jump_addr  out  32  jump fetch address (imem JumpA).
- imem_rd0..imem_rd3  in  32 each  instructions at imem_addr+0/4/8/12.
- imem_jump_rd0..imem_jump_rd3  in  32 each  instructions at imem_jump_addr+0/4/8/12.
- redirect_valid  in  1  taken jump/branch this cycle.
- redirect_pc  in  32  target PC; bits [1:0] ignored.
- out_valid  out  4  bit i set when slot i holds an instruction (thermometer code).
- out_inst0..out_inst3  out  32 each  oldest-first instructions.
- out_pc0..out_pc3  out  32 each  PCs of out_inst0..3.
- deq_count  in  3  number of slots decode consumes this cycle, 0..4.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - pc = RESET_PC, head = 0, tail = 0, count = 0.
  - out_valid = 4'b0000.
  - imem_addr = RESET_PC in the following cycle.
  - Entry storage is not reset.
- Address outputs:
  - imem_addr = pc register, combinational.
  - imem_jump_addr = {redirect_pc[31:2], 2'b00}, combinational, driven whether or not redirect_valid is set.
  - The memory is read combinationally, so data is used in the same cycle; no request/response latency.
- Outputs: out_valid[i] = (count > i). out_inst_i/out_pc_i = entry[(head+i) mod DEPTH], combinational from registers.
- Dequeue:
  - eff_deq = min(deq_count, count); values above 4 are treated as 4.
  - head advances by eff_deq, mod DEPTH.
- Normal enqueue (redirect_valid = 0):
  - Fetch only when DEPTH - count >= 4, using the registered count. The same-cycle dequeue is ignored, so there is no combinational path from deq_count to imem_addr.
  - On fetch: write imem_rd0..3 with PCs pc, pc+4, pc+8, pc+12 at tail..tail+3 (wrapping), then tail += 4 and pc += 16.
  - No fetch: pc and tail hold.
  - count_next = count + (fetch ? 4 : 0) - eff_deq.
- Redirect (redirect_valid = 1): overrides everything that cycle.
  - All entries discarded; deq_count ignored.
  - imem_jump_rd0..3 written at entries 0..3 with PCs T, T+4, T+8, T+12, where T = aligned redirect_pc.
  - head = 0, tail = 4, count = 4, pc = T+16.
  - Decode sees the target bundle next cycle.
- Wrap-around: all index arithmetic is mod DEPTH; the PC wraps mod 2^32 with no special handling.
- Full: count == DEPTH, or DEPTH - count < 4, stalls fetch. Output slots stay valid.
- Empty: count == 0 gives out_valid = 0; deq_count is ignored.
- Reset asserted together with redirect_valid: reset wins.
- Reset mid-operation discards all entries.
- Invariant: 0 <= count <= DEPTH; an assertion fires on violation.

Decomposition:
- Shared package fetch_pkg:
  - FETCH_W = 4.
  - INST_W = 32.
  - Entry record {pc[31:0], inst[31:0]}.
  - Index-width function clog2(DEPTH).
- One sub-module, fetch_queue_storage:
  - DEPTH x 64-bit register array with 4 write ports at consecutive wrapped indices.
  - 4 combinational read ports at head+0..3.
  - Occupancy, pointer and PC control stay in fetch_queue.

Test Plan:
- Reset, then hold deq_count = 0 with imem returning 0x11,0x22,0x33,0x44 → cycle 1: out_valid = 4'b1111, out_pc0..3 = 0,4,8,12; after the second fetch count = 8 = DEPTH, imem_addr holds at 32'h20.
- From full, deq_count = 3 → out_pc0 = 12 next cycle, count = 5, fetch stalled (free 3 < 4); next cycle deq_count = 1 → free 4, fetch resumes, pc 32'h20 → 32'h30.
- redirect_valid = 1, redirect_pc = 32'h103, deq_count = 4 on the same cycle → imem_jump_addr = 32'h100; next cycle out_pc0..3 = 100,104,108,10C, count = 4, imem_addr = 32'h110.
- Steady state with deq_count = 4 every cycle for 10 cycles → head/tail wrap past DEPTH; PCs stay contiguous and out_valid stays 4'b1111.
- count = 2 with deq_count = 4 → clamped; next cycle count = 4 (fetch of 4 added), no underflow assertion.
- reset asserted for one cycle while count = 6 and redirect_valid = 1 → next cycle out_valid = 0, imem_addr = RESET_PC.
